aes_round_ctrl: RTL and testbench

Round sequencer for AES-128 encryption. Owns the 128-bit state register, applies AddRoundKey internally, and drives the external SubBytes, ShiftRows and MixColumns units through start/done handshakes in FIPS-197 order. It requests round keys by index from the key-schedule block. It sits between the top-level cipher interface and the per-stage datapath units.

---
 rtl/aes_round_ctrl.sv | 148 ++++++++++++++
 tb/tb_aes_round_ctrl.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: holds the cipher state, applies AddRoundKey itself and
// walks the external SubBytes/ShiftRows/MixColumns units through start/done handshakes.
module aes_round_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_in,
   input  logic [31:0] pt0,
   input  logic [31:0] pt1,
   input  logic [31:0] pt2,
   input  logic [31:0] pt3,
   output logic [3:0]  rk_idx,
   input  logic [31:0] rk0,
   input  logic [31:0] rk1,
   input  logic [31:0] rk2,
   input  logic [31:0] rk3,
   output logic [31:0] st_out0,
   output logic [31:0] st_out1,
   output logic [31:0] st_out2,
   output logic [31:0] st_out3,
   output logic        sb_start,
   output logic        sr_start,
   output logic        mc_start,
   input  logic        sb_done,
   input  logic        sr_done,
   input  logic        mc_done,
   input  logic [31:0] sb_q0,
   input  logic [31:0] sb_q1,
   input  logic [31:0] sb_q2,
   input  logic [31:0] sb_q3,
   input  logic [31:0] sr_q0,
   input  logic [31:0] sr_q1,
   input  logic [31:0] sr_q2,
   input  logic [31:0] sr_q3,
   input  logic [31:0] mc_q0,
   input  logic [31:0] mc_q1,
   input  logic [31:0] mc_q2,
   input  logic [31:0] mc_q3,
   output logic [31:0] ct0,
   output logic [31:0] ct1,
   output logic [31:0] ct2,
   output logic [31:0] ct3,
   output logic        busy,
   output logic        done
);

   localparam logic [3:0] NR = 4'd10;

   typedef enum logic [3:0] {
      IDLE, LOAD, ARK, SB_S, SB_W, SR_S, SR_W, MC_S, MC_W, DONE
   } fsm_t;

   fsm_t              fsm, fsm_next;
   logic [3:0][31:0]  st, st_next;
   logic [3:0]        round, round_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         fsm   <= IDLE;
         st    <= '0;
         round <= '0;
      end else begin
         fsm   <= fsm_next;
         st    <= st_next;
         round <= round_next;
      end
   end

   // Done pulses are only looked at in the matching wait state, so a pulse that
   // coincides with its own start (or arrives stray) never touches the state.
   always_comb begin
      fsm_next   = fsm;
      st_next    = st;
      round_next = round;
      sb_start   = 1'b0;
      sr_start   = 1'b0;
      mc_start   = 1'b0;
      done       = 1'b0;
      case (fsm)
         IDLE: begin
            if (start_in) fsm_next = LOAD;
         end
         LOAD: begin
            st_next    = {pt3, pt2, pt1, pt0};
            round_next = 4'd0;
            fsm_next   = ARK;
         end
         ARK: begin
            st_next = st ^ {rk3, rk2, rk1, rk0};
            if (round == NR) begin
               fsm_next = DONE;
            end else begin
               round_next = round + 4'd1;
               fsm_next   = SB_S;
            end
         end
         SB_S: begin
            sb_start = 1'b1;
            fsm_next = SB_W;
         end
         SB_W: begin
            if (sb_done) begin
               st_next  = {sb_q3, sb_q2, sb_q1, sb_q0};
               fsm_next = SR_S;
            end
         end
         SR_S: begin
            sr_start = 1'b1;
            fsm_next = SR_W;
         end
         // The last round goes straight from ShiftRows to the final AddRoundKey.
         SR_W: begin
            if (sr_done) begin
               st_next  = {sr_q3, sr_q2, sr_q1, sr_q0};
               fsm_next = (round < NR) ? MC_S : ARK;
            end
         end
         MC_S: begin
            mc_start = 1'b1;
            fsm_next = MC_W;
         end
         MC_W: begin
            if (mc_done) begin
               st_next  = {mc_q3, mc_q2, mc_q1, mc_q0};
               fsm_next = ARK;
            end
         end
         DONE: begin
            done     = 1'b1;
            fsm_next = IDLE;
         end
         default: begin
            fsm_next = IDLE;
         end
      endcase
   end

   assign busy    = (fsm != IDLE);
   assign rk_idx  = round;
   assign st_out0 = st[0];
   assign st_out1 = st[1];
   assign st_out2 = st[2];
   assign st_out3 = st[3];
   assign ct0     = st[0];
   assign ct1     = st[1];
   assign ct2     = st[2];
   assign ct3     = st[3];

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: behavioural AES units and key schedule, a plain AES-128
// reference model, and a scoreboard checked whenever the sequencer raises done.
module tb_aes_round_ctrl;

   localparam int NR = 10;

   logic        clk = 1'b0;
   logic        reset, start_in;
   logic [31:0] pt0, pt1, pt2, pt3, rk0, rk1, rk2, rk3;
   logic [31:0] st_out0, st_out1, st_out2, st_out3, ct0, ct1, ct2, ct3;
   logic [31:0] sb_q0, sb_q1, sb_q2, sb_q3, sr_q0, sr_q1, sr_q2, sr_q3;
   logic [31:0] mc_q0, mc_q1, mc_q2, mc_q3;
   logic [3:0]  rk_idx;
   logic        sb_start, sr_start, mc_start, sb_done, sr_done, mc_done, busy, done;

   logic [127:0] pt_all, sb_res, sr_res, mc_res, st_all, ct_all, cur_key;
   logic [127:0] round_keys [16];
   logic [7:0]   sbox [256];
   logic         sb_done_u = 1'b0, sr_done_u = 1'b0, mc_done_u = 1'b0;
   logic         sb_spur = 1'b0, mc_spur = 1'b0;

   typedef struct {
      logic [127:0] ct;
      int           cyc;
   } exp_t;
   exp_t scoreboard [$];
   int   rk_log [$];

   int cyc = 0, n_checks = 0, n_fail = 0, n_pushed = 0, n_done_seen = 0;
   int lat_sb = 1, lat_sr = 1, lat_mc = 1, free_at = 0;
   int outstanding = 0, n_sbs = 0, n_srs = 0, n_mcs = 0, n_srd = 0, ark_at = -1;
   bit new_enc = 1'b0, load_pending = 1'b0, pend_has_gold = 1'b0;
   int pend_cyc = 0;
   logic [127:0] pend_gold, last_exp_ct = '0;

   localparam logic [127:0] FIPS_PT  = 128'hffeeddcc_bbaa9988_77665544_33221100;
   localparam logic [127:0] FIPS_KEY = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
   localparam logic [127:0] FIPS_CT  = 128'h5ac5b470_80b7cdd8_30047b6a_d8e0c469;

   assign {pt3, pt2, pt1, pt0}             = pt_all;
   assign {rk3, rk2, rk1, rk0}             = round_keys[rk_idx];
   assign {sb_q3, sb_q2, sb_q1, sb_q0}     = sb_res;
   assign {sr_q3, sr_q2, sr_q1, sr_q0}     = sr_res;
   assign {mc_q3, mc_q2, mc_q1, mc_q0}     = mc_res;
   assign st_all  = {st_out3, st_out2, st_out1, st_out0};
   assign ct_all  = {ct3, ct2, ct1, ct0};
   assign sb_done = sb_done_u | sb_spur;
   assign sr_done = sr_done_u;
   assign mc_done = mc_done_u | mc_spur;

   aes_round_ctrl dut (
      .clk(clk), .reset(reset), .start_in(start_in),
      .pt0(pt0), .pt1(pt1), .pt2(pt2), .pt3(pt3),
      .rk_idx(rk_idx), .rk0(rk0), .rk1(rk1), .rk2(rk2), .rk3(rk3),
      .st_out0(st_out0), .st_out1(st_out1), .st_out2(st_out2), .st_out3(st_out3),
      .sb_start(sb_start), .sr_start(sr_start), .mc_start(mc_start),
      .sb_done(sb_done), .sr_done(sr_done), .mc_done(mc_done),
      .sb_q0(sb_q0), .sb_q1(sb_q1), .sb_q2(sb_q2), .sb_q3(sb_q3),
      .sr_q0(sr_q0), .sr_q1(sr_q1), .sr_q2(sr_q2), .sr_q3(sr_q3),
      .mc_q0(mc_q0), .mc_q1(mc_q1), .mc_q2(mc_q2), .mc_q3(mc_q3),
      .ct0(ct0), .ct1(ct1), .ct2(ct2), .ct3(ct3),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // AES arithmetic; a state byte (row r, column c) lives at bits 8*(4c+r).
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = '0; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = xt(aa);
         bb = bb >> 1;
      end
      return p;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, b;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h01;
         for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
         b = inv;
         sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox[s[8*i +: 8]];
      return o;
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[32*c +: 8]; a1 = s[32*c+8 +: 8]; a2 = s[32*c+16 +: 8]; a3 = s[32*c+24 +: 8];
         o[32*c +: 8]    = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
         o[32*c+8 +: 8]  = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
         o[32*c+16 +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
         o[32*c+24 +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
      return o;
   endfunction

   function automatic logic [127:0] round_key(input logic [127:0] key, input int k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[7:0], t[31:8]};
            for (int j = 0; j < 4; j++) t[8*j +: 8] = sbox[t[8*j +: 8]];
            t = t ^ {24'h0, rcon};
            rcon = xt(rcon);
         end
         w[i] = w[i-4] ^ t;
      end
      return {w[4*k+3], w[4*k+2], w[4*k+1], w[4*k]};
   endfunction

   function automatic logic [127:0] aes_ref(input logic [127:0] p, input logic [127:0] key);
      logic [127:0] s;
      s = p ^ round_key(key, 0);
      for (int r = 1; r < NR; r++) s = mix_columns(shift_rows(sub_bytes(s))) ^ round_key(key, r);
      return shift_rows(sub_bytes(s)) ^ round_key(key, NR);
   endfunction

   function automatic int enc_cycles();
      return 3 + (NR - 1) * (lat_sb + lat_sr + lat_mc + 4) + (lat_sb + lat_sr + 3);
   endfunction

   task automatic set_key(input logic [127:0] key);
      cur_key = key;
      for (int i = 0; i < 16; i++) round_keys[i] = (i <= NR) ? round_key(key, i) : '0;
   endtask

   task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Behavioural units: capture the state bus at start, answer L cycles later.
   initial begin
      logic [127:0] cap;
      sb_res = '0;
      forever begin
         @(negedge clk);
         if (sb_start) begin
            cap = st_all;
            repeat (lat_sb) @(posedge clk);
            #1 sb_res = sub_bytes(cap); sb_done_u = 1'b1;
            @(posedge clk);
            #1 sb_done_u = 1'b0;
         end
      end
   end

   initial begin
      logic [127:0] cap;
      sr_res = '0;
      forever begin
         @(negedge clk);
         if (sr_start) begin
            cap = st_all;
            repeat (lat_sr) @(posedge clk);
            #1 sr_res = shift_rows(cap); sr_done_u = 1'b1;
            @(posedge clk);
            #1 sr_done_u = 1'b0;
         end
      end
   end

   initial begin
      logic [127:0] cap;
      mc_res = '0;
      forever begin
         @(negedge clk);
         if (mc_start) begin
            cap = st_all;
            repeat (lat_mc) @(posedge clk);
            #1 mc_res = mix_columns(cap); mc_done_u = 1'b1;
            @(posedge clk);
            #1 mc_done_u = 1'b0;
         end
      end
   end

   // Monitor: handshake bookkeeping plus scoreboard pop on every done pulse.
   initial begin
      exp_t         e;
      logic [43:0]  got_seq, exp_seq;
      forever begin
         @(negedge clk);
         if (new_enc) begin
            n_sbs = 0; n_srs = 0; n_mcs = 0; n_srd = 0;
            rk_log.delete();
            ark_at  = cyc + 2;
            new_enc = 1'b0;
         end
         if (cyc == ark_at) rk_log.push_back(int'(rk_idx));
         if (sb_done_u) outstanding--;
         if (sr_done_u) begin
            outstanding--;
            n_srd++;
            if (n_srd == NR) ark_at = cyc + 1;
         end
         if (mc_done_u) begin
            outstanding--;
            ark_at = cyc + 1;
         end
         if (sb_start || sr_start || mc_start) begin
            check_output("single_outstanding", 128'(outstanding), 128'd0);
            outstanding++;
         end
         if (sb_start) n_sbs++;
         if (sr_start) n_srs++;
         if (mc_start) begin
            n_mcs++;
            check_output("mc_before_last_sr", 128'(n_srd < NR), 128'd1);
         end
         if (done) begin
            n_done_seen++;
            check_output("done_expected", 128'(scoreboard.size() != 0), 128'd1);
            if (scoreboard.size() != 0) begin
               e = scoreboard.pop_front();
               last_exp_ct = e.ct;
               check_output("ct", ct_all, e.ct);
               check_output("st_out", st_all, e.ct);
               check_output("done_cycle", 128'(cyc), 128'(e.cyc));
               check_output("sb_start_count", 128'(n_sbs), 128'(NR));
               check_output("sr_start_count", 128'(n_srs), 128'(NR));
               check_output("mc_start_count", 128'(n_mcs), 128'(NR - 1));
               got_seq = '0;
               exp_seq = '0;
               for (int i = 0; i <= NR; i++) begin
                  exp_seq[4*i +: 4] = 4'(i);
                  if (i < rk_log.size()) got_seq[4*i +: 4] = 4'(rk_log[i]);
               end
               check_output("rk_idx_count", 128'(rk_log.size()), 128'(NR + 1));
               check_output("rk_idx_sequence", 128'(got_seq), 128'(exp_seq));
            end
         end
         while (scoreboard.size() != 0 && cyc > scoreboard[0].cyc) begin
            check_output("missing_done", 128'(cyc), 128'(scoreboard[0].cyc));
            void'(scoreboard.pop_front());
         end
      end
   end

   // One cycle of stimulus; the model decides acceptance and captures pt in the LOAD cycle.
   task automatic apply_stimulus(input bit go, input logic [127:0] p,
                                 input bit has_gold, input logic [127:0] gold);
      exp_t e;
      start_in = go;
      pt_all   = p;
      if (load_pending) begin
         e.ct  = pend_has_gold ? pend_gold : aes_ref(p, cur_key);
         e.cyc = pend_cyc;
         scoreboard.push_back(e);
         n_pushed++;
         load_pending = 1'b0;
      end
      if (go && !reset && cyc >= free_at) begin
         pend_cyc      = cyc + enc_cycles();
         free_at       = pend_cyc + 1;
         load_pending  = 1'b1;
         pend_has_gold = has_gold;
         pend_gold     = gold;
         new_enc       = 1'b1;
      end
      tick();
   endtask

   task automatic run_one(input logic [127:0] p, input bit has_gold, input logic [127:0] gold);
      apply_stimulus(1'b1, p, has_gold, gold);
      apply_stimulus(1'b0, p, has_gold, gold);
   endtask

   task automatic wait_idle();
      while (cyc < free_at) tick();
   endtask

   task automatic check_hold();
      wait_idle();
      repeat (2) tick();
      check_output("ct_hold_after_done", ct_all, last_exp_ct);
   endtask

   task automatic do_reset(input int n);
      reset    = 1'b1;
      start_in = 1'b0;
      n_pushed = n_pushed - scoreboard.size();
      scoreboard.delete();
      load_pending = 1'b0;
      repeat (n) tick();
      reset   = 1'b0;
      free_at = cyc;
   endtask

   task automatic check_idle_outputs(input string name);
      check_output({name, "_ct"}, ct_all, '0);
      check_output({name, "_st_out"}, st_all, '0);
      check_output({name, "_ctrl"}, 128'({busy, done, sb_start, sr_start, mc_start}), 128'd0);
      check_output({name, "_rk_idx"}, 128'(rk_idx), 128'd0);
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [127:0] p;
      bit           hit;
      reset = 1'b1; start_in = 1'b0; pt_all = '0;
      build_sbox();
      set_key(FIPS_KEY);
      do_reset(2);
      check_idle_outputs("reset");

      $display("[TB] FIPS-197 vector, unit latency 1 and 3");
      run_one(FIPS_PT, 1'b1, FIPS_CT);
      check_hold();
      lat_sb = 3; lat_sr = 3; lat_mc = 3;
      run_one(FIPS_PT, 1'b1, FIPS_CT);
      check_hold();

      $display("[TB] start_in held high with changing plaintext");
      lat_sb = 1; lat_sr = 1; lat_mc = 1;
      for (int i = 0; i < 2 * (enc_cycles() + 1) + 5; i++) apply_stimulus(1'b1, rand128(), 1'b0, '0);
      apply_stimulus(1'b0, pt_all, 1'b0, '0);
      wait_idle();

      $display("[TB] second start while busy");
      run_one(FIPS_PT, 1'b1, FIPS_CT);
      repeat (20) tick();
      apply_stimulus(1'b1, rand128(), 1'b0, '0);
      apply_stimulus(1'b0, rand128(), 1'b0, '0);
      check_hold();

      $display("[TB] stray done pulses in SB_S and SB_W");
      lat_sb = 3;
      run_one(FIPS_PT, 1'b1, FIPS_CT);
      tick();
      sb_spur = 1'b1;
      tick();
      sb_spur = 1'b0;
      mc_spur = 1'b1;
      tick();
      mc_spur = 1'b0;
      check_hold();

      $display("[TB] reset during round 5 MixColumns wait");
      lat_sb = 1; lat_sr = 1; lat_mc = 4;
      run_one(FIPS_PT, 1'b1, FIPS_CT);
      hit = 1'b0;
      for (int i = 0; i < 600 && !hit; i++) begin
         tick();
         hit = (n_mcs >= 5);
      end
      check_output("reach_round5_mc_wait", 128'(hit), 128'd1);
      do_reset(1);
      repeat (6) tick();
      check_output("pending_mc_done_delivered", 128'(outstanding), 128'd0);
      check_idle_outputs("after_reset");
      run_one(FIPS_PT, 1'b1, FIPS_CT);
      check_hold();

      $display("[TB] randomized keys, plaintexts and latencies");
      for (int n = 0; n < 6; n++) begin
         wait_idle();
         set_key(rand128());
         lat_sb = $urandom_range(4, 1);
         lat_sr = $urandom_range(4, 1);
         lat_mc = $urandom_range(4, 1);
         repeat ($urandom_range(3, 0)) tick();
         p = rand128();
         run_one(p, 1'b0, '0);
      end
      check_hold();

      repeat (3) tick();
      check_output("scoreboard_empty", 128'(scoreboard.size()), 128'd0);
      check_output("done_pulse_count", 128'(n_done_seen), 128'(n_pushed));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      repeat (20000) @(posedge clk);
      n_fail++;
      $display("[TB] FAIL watchdog: simulation exceeded 20000 cycles");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
